// File: rtl/multi_shift_reg.sv
// multi_shift_reg: WIDTH-bit register with an op-code command interface.
// Commands: hold, load, shift left/right, rotate left/right, increment and
// decrement. Shifts and rotates of amt bits take amt clocks, one bit per
// clock, with busy asserted while the command is still running. done pulses
// for one cycle when a command completes. Reset loads the register from the
// run-time value d_value.
// Optional feature: define MULTI_SHIFT_REG_CARRY_EN to add the registered
// carry/shift-out output co.
module multi_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_value,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
  input  logic             si,
`ifdef MULTI_SHIFT_REG_CARRY_EN
  output logic             co,
`endif
  output logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_o;
  logic [AMT_W-1:0] r_count;
  logic [2:0]       r_op;
  logic             r_si;
  logic             r_done;

  logic [2:0]       w_step_op;
  logic             w_step_si;
  logic [WIDTH-1:0] w_step;

  // One shift/rotate step of value v.
  function automatic logic [WIDTH-1:0] step_val(input logic [2:0] f_op,
                                                input logic [WIDTH-1:0] f_v,
                                                input logic f_si);
    case (f_op)
      OP_SHL:  return {f_v[WIDTH-2:0], f_si};
      OP_SHR:  return {f_si, f_v[WIDTH-1:1]};
      OP_ROL:  return {f_v[WIDTH-2:0], f_v[WIDTH-1]};
      OP_ROR:  return {f_v[0], f_v[WIDTH-1:1]};
      default: return f_v;
    endcase
  endfunction

  // While running, the step uses the op and serial bit captured at acceptance.
  always_comb begin
    w_step_op = (r_state == S_RUN) ? r_op : op;
    w_step_si = (r_state == S_RUN) ? r_si : si;
    w_step    = step_val(w_step_op, r_o, w_step_si);
  end

  // Command FSM: register contents, step counter, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o     <= d_value;
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (en) begin
            case (op)
              OP_HOLD: r_done <= 1'b1;
              OP_LOAD: begin
                r_o    <= in;
                r_done <= 1'b1;
              end
              OP_INC: begin
                r_o    <= r_o + WIDTH'(1);
                r_done <= 1'b1;
              end
              OP_DEC: begin
                r_o    <= r_o - WIDTH'(1);
                r_done <= 1'b1;
              end
              default: begin
                // Shift/rotate: first step happens on the acceptance edge.
                if (amt == '0) begin
                  r_done <= 1'b1;
                end else begin
                  r_o <= w_step;
                  if (amt == AMT_W'(1)) begin
                    r_done <= 1'b1;
                  end else begin
                    r_count <= amt - AMT_W'(1);
                    r_op    <= op;
                    r_si    <= si;
                    r_state <= S_RUN;
                  end
                end
              end
            endcase
          end
        end
        S_RUN: begin
          r_o     <= w_step;
          r_count <= r_count - AMT_W'(1);
          if (r_count == AMT_W'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MULTI_SHIFT_REG_CARRY_EN
  logic r_co;

  // Bit leaving the register on one shift/rotate step.
  function automatic logic step_out(input logic [2:0] f_op,
                                    input logic [WIDTH-1:0] f_v);
    case (f_op)
      OP_SHL, OP_ROL: return f_v[WIDTH-1];
      OP_SHR, OP_ROR: return f_v[0];
      default:        return 1'b0;
    endcase
  endfunction

  // Carry/borrow for INC/DEC, shifted-out bit for each shift/rotate step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_co <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_co <= step_out(r_op, r_o);
    end else if (en) begin
      case (op)
        OP_INC:                         r_co <= &r_o;
        OP_DEC:                         r_co <= ~|r_o;
        OP_SHL, OP_SHR, OP_ROL, OP_ROR: r_co <= (amt == '0) ? 1'b0 : step_out(op, r_o);
        default:                        r_co <= 1'b0;
      endcase
    end
  end

  assign co = r_co;
`endif

  assign o    = r_o;
  assign busy = (r_state == S_RUN);
  assign done = r_done;

endmodule

// File: tb/tb_multi_shift_reg.sv
// Directed testbench for multi_shift_reg (WIDTH=8, AMT_W=3).
// Carry output checks are compiled in when MULTI_SHIFT_REG_CARRY_EN is defined.
module tb_multi_shift_reg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d_value = 8'h00;
  logic       en = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] in = 8'h00;
  logic [2:0] amt = 3'd0;
  logic       si = 1'b0;
  logic [7:0] o;
  logic       busy;
  logic       done;
`ifdef MULTI_SHIFT_REG_CARRY_EN
  logic       co;
`endif

  int n_checks = 0;
  int n_fail = 0;

  multi_shift_reg #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .d_value(d_value), .en(en), .op(op), .in(in),
    .amt(amt), .si(si),
`ifdef MULTI_SHIFT_REG_CARRY_EN
    .co(co),
`endif
    .o(o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_o(input string name, input logic [7:0] exp);
    n_checks++;
    if (o !== exp) begin n_fail++; $display("FAIL %s o: got %h expected %h", name, o, exp); end
  endtask

  task automatic chk_bd(input string name, input logic exp_busy, input logic exp_done);
    n_checks++;
    if (busy !== exp_busy) begin n_fail++; $display("FAIL %s busy: got %b expected %b", name, busy, exp_busy); end
    n_checks++;
    if (done !== exp_done) begin n_fail++; $display("FAIL %s done: got %b expected %b", name, done, exp_done); end
  endtask

  task automatic chk_co(input string name, input logic exp);
`ifdef MULTI_SHIFT_REG_CARRY_EN
    n_checks++;
    if (co !== exp) begin n_fail++; $display("FAIL %s co: got %b expected %b", name, co, exp); end
`endif
  endtask

  // Single-edge LOAD used to set up a starting value.
  task automatic do_load(input logic [7:0] v);
    en = 1'b1; op = OP_LOAD; in = v;
    tick();
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; d_value = 8'hA5; en = 1'b1; op = OP_LOAD; in = 8'h77;
    tick();
    rst = 1'b0; en = 1'b0;
    chk_o("reset", 8'hA5);
    chk_bd("reset", 1'b0, 1'b0);
    chk_co("reset", 1'b0);
  endtask

  task automatic test_load();
    en = 1'b1; op = OP_LOAD; in = 8'h3C;
    tick();
    en = 1'b0;
    chk_o("load", 8'h3C);
    chk_bd("load", 1'b0, 1'b1);
    chk_co("load", 1'b0);
    tick();
    chk_o("load_after", 8'h3C);
    chk_bd("load_after", 1'b0, 1'b0);
  endtask

  task automatic test_shl();
    do_load(8'h81);
    en = 1'b1; op = OP_SHL; amt = 3'd3; si = 1'b1;
    tick();
    en = 1'b0; si = 1'b0; op = OP_HOLD;
    chk_o("shl_e1", 8'h03);
    chk_bd("shl_e1", 1'b1, 1'b0);
    chk_co("shl_e1", 1'b1);
    tick();
    chk_o("shl_e2", 8'h07);
    chk_bd("shl_e2", 1'b1, 1'b0);
    chk_co("shl_e2", 1'b0);
    tick();
    chk_o("shl_e3", 8'h0F);
    chk_bd("shl_e3", 1'b0, 1'b1);
    chk_co("shl_e3", 1'b0);
    tick();
    chk_o("shl_e4", 8'h0F);
    chk_bd("shl_e4", 1'b0, 1'b0);
  endtask

  task automatic test_ror_busy_ignore();
    do_load(8'h3C);
    en = 1'b1; op = OP_ROR; amt = 3'd4;
    tick();
    chk_o("ror_e1", 8'h1E);
    chk_bd("ror_e1", 1'b1, 1'b0);
    op = OP_LOAD; in = 8'hFF;
    tick();
    en = 1'b0;
    chk_o("ror_e2", 8'h0F);
    chk_bd("ror_e2", 1'b1, 1'b0);
    tick();
    chk_o("ror_e3", 8'h87);
    chk_bd("ror_e3", 1'b1, 1'b0);
    en = 1'b1; op = OP_INC;
    tick();
    en = 1'b0;
    chk_o("ror_e4", 8'hC3);
    chk_bd("ror_e4", 1'b0, 1'b1);
    chk_co("ror_e4", 1'b1);
    tick();
    chk_o("ror_after", 8'hC3);
    chk_bd("ror_after", 1'b0, 1'b0);
  endtask

  task automatic test_inc_dec();
    do_load(8'hFF);
    en = 1'b1; op = OP_INC;
    tick();
    chk_o("inc_wrap", 8'h00);
    chk_bd("inc_wrap", 1'b0, 1'b1);
    chk_co("inc_wrap", 1'b1);
    op = OP_DEC;
    tick();
    chk_o("dec_borrow", 8'hFF);
    chk_bd("dec_borrow", 1'b0, 1'b1);
    chk_co("dec_borrow", 1'b1);
    tick();
    en = 1'b0;
    chk_o("dec_plain", 8'hFE);
    chk_co("dec_plain", 1'b0);
    tick();
  endtask

  task automatic test_reset_abort();
    do_load(8'hF0);
    en = 1'b1; op = OP_SHR; amt = 3'd7; si = 1'b0;
    tick();
    en = 1'b0;
    chk_o("abort_e1", 8'h78);
    tick();
    chk_o("abort_e2", 8'h3C);
    chk_bd("abort_e2", 1'b1, 1'b0);
    rst = 1'b1; d_value = 8'h11;
    tick();
    rst = 1'b0;
    chk_o("abort_rst", 8'h11);
    chk_bd("abort_rst", 1'b0, 1'b0);
    chk_co("abort_rst", 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_o("abort_hold", 8'h11);
      chk_bd("abort_hold", 1'b0, 1'b0);
    end
  endtask

  task automatic test_short_ops();
    do_load(8'hB4);
    en = 1'b1; op = OP_HOLD;
    tick();
    chk_o("hold", 8'hB4);
    chk_bd("hold", 1'b0, 1'b1);
    op = OP_ROL; amt = 3'd0;
    tick();
    chk_o("rol_amt0", 8'hB4);
    chk_bd("rol_amt0", 1'b0, 1'b1);
    chk_co("rol_amt0", 1'b0);
    amt = 3'd1;
    tick();
    chk_o("rol_amt1", 8'h69);
    chk_bd("rol_amt1", 1'b0, 1'b1);
    chk_co("rol_amt1", 1'b1);
    op = OP_SHR; si = 1'b1;
    tick();
    en = 1'b0;
    chk_o("shr_amt1", 8'hB4);
    chk_bd("shr_amt1", 1'b0, 1'b1);
    chk_co("shr_amt1", 1'b1);
    tick();
    chk_bd("short_idle", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_load(8'h01);
    en = 1'b1; op = OP_ROL; amt = 3'd2;
    tick();
    en = 1'b0;
    tick();
    chk_o("b2b_first", 8'h04);
    chk_bd("b2b_first", 1'b0, 1'b1);
    en = 1'b1; op = OP_ROR; amt = 3'd3;
    tick();
    en = 1'b0;
    chk_o("b2b_second_e1", 8'h02);
    chk_bd("b2b_second_e1", 1'b1, 1'b0);
    tick();
    tick();
    chk_o("b2b_second_done", 8'h80);
    chk_bd("b2b_second_done", 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl();
    test_ror_busy_ignore();
    test_inc_dec();
    test_reset_abort();
    test_short_ops();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
